// File: rtl/scnn_pkg.sv
// Shared types and default sizing for the SCNN weight-compression datapath.
//   SCNN_N / SCNN_DW / SCNN_IW : default tile size, weight width, run-index width
//   scnn_state_e               : tile sequencing states
//   scnn_entry_t               : {data, ind} compressed entry at default widths
package scnn_pkg;

  localparam int unsigned SCNN_N  = 25;
  localparam int unsigned SCNN_DW = 16;
  localparam int unsigned SCNN_IW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scnn_state_e;

  typedef struct packed {
    logic [SCNN_DW-1:0] data;
    logic [SCNN_IW-1:0] ind;
  } scnn_entry_t;

endpackage

// File: rtl/scnn_out_reg.sv
// Single-entry valid/ready output register.
//   load/load_data : capture a new word; takes priority over a handshake
//   out_valid/out_ready/out_data : downstream handshake; data held while stalled
// The producer must only load when the slot is empty or draining this cycle.
module scnn_out_reg #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Load replaces the current word; otherwise a handshake empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/scnn_wt_compress_stream.sv
// Streaming SCNN weight compressor: one dense tile of N weights in, a stream of
// (value, zero-run) entries out. Runs longer than 2**IW-1 are broken by a
// zero-valued filler entry.
//   start/busy           : tile launch, busy until the done pulse
//   in_valid/in_ready/in_data : dense element stream (in_ready is combinational)
//   out_valid/out_ready/out_data/out_ind : compressed entry stream
//   done/nz_count        : end-of-tile pulse and entry count (held after done)
module scnn_wt_compress_stream
  import scnn_pkg::*;
#(
  parameter int unsigned N  = SCNN_N,
  parameter int unsigned DW = SCNN_DW,
  parameter int unsigned IW = SCNN_IW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IW-1:0]         out_ind,
  output logic                  done,
  output logic [$clog2(N+1)-1:0] nz_count
);

  localparam int unsigned CW      = $clog2(N + 1);
  localparam int unsigned MAX_RUN = (1 << IW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] ind;
  } entry_t;

  scnn_state_e   state_q, state_d;
  logic [IW-1:0] run_q, run_d;
  logic [CW-1:0] elem_cnt_q, elem_cnt_d;
  logic [CW-1:0] entry_cnt_q, entry_cnt_d;
  logic [CW-1:0] nz_count_q, nz_count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          load;
  entry_t        load_entry;
  entry_t        out_entry;

  // Accept only when the output slot is free or being drained this cycle.
  assign in_ready = (state_q == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Tile sequencing, run-length encoding and entry generation.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    elem_cnt_d  = elem_cnt_q;
    entry_cnt_d = entry_cnt_q;
    load        = 1'b0;
    load_entry  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          run_d       = '0;
          elem_cnt_d  = '0;
          entry_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          elem_cnt_d = elem_cnt_q + CW'(1);
          if (in_data != '0) begin
            load            = 1'b1;
            load_entry.data = in_data;
            load_entry.ind  = run_q;
            run_d           = '0;
            entry_cnt_d     = entry_cnt_q + CW'(1);
          end else if (run_q == IW'(MAX_RUN)) begin
            // Run index saturated: this zero becomes a filler entry.
            load            = 1'b1;
            load_entry.data = '0;
            load_entry.ind  = run_q;
            run_d           = '0;
            entry_cnt_d     = entry_cnt_q + CW'(1);
          end else begin
            run_d = run_q + IW'(1);
          end
          if (elem_cnt_q == CW'(N - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    nz_count_d = (state_d == DONE) ? entry_cnt_d : nz_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= '0;
      elem_cnt_q  <= '0;
      entry_cnt_q <= '0;
      nz_count_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      elem_cnt_q  <= elem_cnt_d;
      entry_cnt_q <= entry_cnt_d;
      nz_count_q  <= nz_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  scnn_out_reg #(
    .W($bits(entry_t))
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(load_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_entry)
  );

  assign out_data = out_entry.data;
  assign out_ind  = out_entry.ind;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nz_count = nz_count_q;

endmodule

// File: tb/tb_scnn_wt_compress_stream.sv
// Bench for scnn_wt_compress_stream: default instance (N=25, IW=8) and a small
// instance (N=8, IW=2) that exercises filler entries.
module tb_scnn_wt_compress_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic        a_start = 1'b0, a_busy, a_in_valid = 1'b0, a_in_ready;
  logic [15:0] a_in_data = '0;
  logic        a_out_valid, a_out_ready = 1'b1;
  logic [15:0] a_out_data;
  logic [7:0]  a_out_ind;
  logic        a_done;
  logic [4:0]  a_nz;

  // Small instance
  logic        b_start = 1'b0, b_busy, b_in_valid = 1'b0, b_in_ready;
  logic [15:0] b_in_data = '0;
  logic        b_out_valid, b_out_ready = 1'b1;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ind;
  logic        b_done;
  logic [3:0]  b_nz;

  scnn_wt_compress_stream u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ind(a_out_ind), .done(a_done), .nz_count(a_nz)
  );

  scnn_wt_compress_stream #(.N(8), .DW(16), .IW(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ind(b_out_ind), .done(b_done), .nz_count(b_nz)
  );

  int n_cmp = 0;
  int n_err = 0;

  int a_exp_d[$], a_exp_i[$], a_got_d[$], a_got_i[$];
  int b_exp_d[$], b_exp_i[$], b_got_d[$], b_got_i[$];
  int a_exp_nz = 0, b_exp_nz = 0;
  int a_done_cnt = 0, b_done_cnt = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void push_exp(input bit to_b, input int d, input int ind);
    if (to_b) begin b_exp_d.push_back(d); b_exp_i.push_back(ind); end
    else      begin a_exp_d.push_back(d); a_exp_i.push_back(ind); end
  endfunction

  // Gap-based model: between consecutive nonzeros (or tile end) a gap of g
  // zeros yields g/(M+1) fillers, then the nonzero carries g%(M+1).
  function automatic void model_tile(input bit to_b, input int vals[$], input int max_run);
    int prev = -1;
    int gap;
    int n = 0;
    for (int p = 0; p <= vals.size(); p++) begin
      if (p == vals.size() || vals[p] != 0) begin
        gap = p - prev - 1;
        for (int k = 0; k < gap / (max_run + 1); k++) begin
          push_exp(to_b, 0, max_run);
          n++;
        end
        if (p < vals.size()) begin
          push_exp(to_b, vals[p], gap % (max_run + 1));
          n++;
        end
        prev = p;
      end
    end
    if (to_b) b_exp_nz = n; else a_exp_nz = n;
  endfunction

  // Compare process: entries on every handshake, hold-stability while
  // stalled, no spurious valid, and count at done.
  bit a_stall = 1'b0, b_stall = 1'b0;
  int a_hold_d, a_hold_i, b_hold_d, b_hold_i;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_stall) begin
        check("a_hold_valid", a_out_valid, 1);
        check("a_hold_data", a_out_data, a_hold_d);
        check("a_hold_ind", a_out_ind, a_hold_i);
      end
      if (a_out_valid) begin
        check("a_entry_expected", a_exp_d.size() > 0, 1);
        if (a_out_ready && a_exp_d.size() > 0) begin
          check("a_data", a_out_data, a_exp_d[0]);
          check("a_ind", a_out_ind, a_exp_i[0]);
          void'(a_exp_d.pop_front());
          void'(a_exp_i.pop_front());
          a_got_d.push_back(int'(a_out_data));
          a_got_i.push_back(int'(a_out_ind));
        end
      end
      if (a_done) begin
        check("a_nz_count", a_nz, a_exp_nz);
        check("a_all_entries_out", a_exp_d.size(), 0);
        a_done_cnt++;
      end
      a_stall  = a_out_valid && !a_out_ready;
      a_hold_d = int'(a_out_data);
      a_hold_i = int'(a_out_ind);

      if (b_stall) begin
        check("b_hold_data", b_out_data, b_hold_d);
        check("b_hold_ind", b_out_ind, b_hold_i);
      end
      if (b_out_valid) begin
        check("b_entry_expected", b_exp_d.size() > 0, 1);
        if (b_out_ready && b_exp_d.size() > 0) begin
          check("b_data", b_out_data, b_exp_d[0]);
          check("b_ind", b_out_ind, b_exp_i[0]);
          void'(b_exp_d.pop_front());
          void'(b_exp_i.pop_front());
          b_got_d.push_back(int'(b_out_data));
          b_got_i.push_back(int'(b_out_ind));
        end
      end
      if (b_done) begin
        check("b_nz_count", b_nz, b_exp_nz);
        check("b_all_entries_out", b_exp_d.size(), 0);
        b_done_cnt++;
      end
      b_stall  = b_out_valid && !b_out_ready;
      b_hold_d = int'(b_out_data);
      b_hold_i = int'(b_out_ind);
    end else begin
      a_stall = 1'b0;
      b_stall = 1'b0;
    end
  end

  task automatic wait_ready_a();
    int w = 0;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      w++;
      if (w > 60) begin
        check("a_in_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Drive one tile into instance A; optional stray start and mid-tile reset.
  task automatic run_a(input int vals[$], input int start_at, input int abort_at);
    int d0;
    int w;
    a_got_d.delete(); a_got_i.delete();
    model_tile(1'b0, vals, 255);
    d0 = a_done_cnt;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    check("a_busy_after_start", a_busy, 1);
    for (int i = 0; i < vals.size(); i++) begin
      if (i == abort_at) begin
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_exp_d.delete(); a_exp_i.delete();
        check("abort_out_valid", a_out_valid, 0);
        check("abort_busy", a_busy, 0);
        check("abort_in_ready", a_in_ready, 0);
        repeat (30) @(negedge clk);
        check("abort_no_done", a_done_cnt - d0, 0);
        return;
      end
      a_in_valid = 1'b1;
      a_in_data  = 16'(vals[i]);
      if (i == start_at) a_start = 1'b1;
      wait_ready_a();
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    a_in_valid = 1'b0;
    w = 0;
    while (a_done_cnt == d0 && w < 80) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("a_done_once", a_done_cnt - d0, 1);
    check("a_busy_after_done", a_busy, 0);
  endtask

  // Hold out_ready low for five cycles once the first entry appears.
  task automatic stall_a();
    int w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!a_out_valid && w < 100);
    check("stall_first_entry_seen", a_out_valid, 1);
    a_out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", a_in_ready, 0);
      check("stall_out_data", a_out_data, 1);
      check("stall_out_ind", a_out_ind, 0);
    end
    @(posedge clk); #1 a_out_ready = 1'b1;
  endtask

  task automatic run_b(input int vals[$]);
    int d0;
    int w;
    b_got_d.delete(); b_got_i.delete();
    model_tile(1'b1, vals, 3);
    d0 = b_done_cnt;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int i = 0; i < vals.size(); i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(vals[i]);
      w = 0;
      forever begin
        @(negedge clk);
        if (b_in_ready) break;
        w++;
        if (w > 60) begin
          check("b_in_ready_timeout", 0, 1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    w = 0;
    while (b_done_cnt == d0 && w < 80) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("b_done_once", b_done_cnt - d0, 1);
    check("b_busy_after_done", b_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[$];
    int pos;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_ind", a_out_ind, 0);
    check("rst_done", a_done, 0);
    check("rst_nz_count", a_nz, 0);
    rst_n = 1'b1;

    // Sparse tile: 0x11@0, 0x22@3, 0x33@24
    v.delete();
    for (int i = 0; i < 25; i++) v.push_back(0);
    v[0] = 32'h11; v[3] = 32'h22; v[24] = 32'h33;
    run_a(v, -1, -1);
    check("t1_entry_count", a_got_d.size(), 3);
    if (a_got_d.size() == 3) begin
      check("t1_e0_data", a_got_d[0], 32'h11); check("t1_e0_ind", a_got_i[0], 0);
      check("t1_e1_data", a_got_d[1], 32'h22); check("t1_e1_ind", a_got_i[1], 2);
      check("t1_e2_data", a_got_d[2], 32'h33); check("t1_e2_ind", a_got_i[2], 20);
    end
    check("t1_nz_held", a_nz, 3);

    // Small instance: long zero run split by a filler entry
    v.delete();
    for (int i = 0; i < 7; i++) v.push_back(0);
    v.push_back(5);
    run_b(v);
    check("t2_entry_count", b_got_d.size(), 2);
    if (b_got_d.size() == 2) begin
      check("t2_e0_data", b_got_d[0], 0); check("t2_e0_ind", b_got_i[0], 3);
      check("t2_e1_data", b_got_d[1], 5); check("t2_e1_ind", b_got_i[1], 3);
      pos = -1 + b_got_i[0] + 1;
      check("t2_pos0", pos, 3);
      pos = pos + b_got_i[1] + 1;
      check("t2_pos1", pos, 7);
    end
    check("t2_nz", b_nz, 2);

    // All-zero tile: no entries at all
    v.delete();
    for (int i = 0; i < 25; i++) v.push_back(0);
    run_a(v, -1, -1);
    check("t3_entry_count", a_got_d.size(), 0);
    check("t3_nz", a_nz, 0);

    // Dense tile 1..25 with a downstream stall after the first entry
    v.delete();
    for (int i = 1; i <= 25; i++) v.push_back(i);
    fork
      run_a(v, -1, -1);
      stall_a();
    join
    check("t4_entry_count", a_got_d.size(), 25);
    if (a_got_d.size() == 25) begin
      for (int i = 0; i < 25; i++) begin
        check("t4_data", a_got_d[i], i + 1);
        check("t4_ind", a_got_i[i], 0);
      end
    end
    check("t4_nz", a_nz, 25);

    // Stray start mid-tile is ignored
    v.delete();
    for (int i = 0; i < 25; i++) v.push_back((i % 4 == 1) ? 100 + i : 0);
    run_a(v, 10, -1);
    check("t5_nz", a_nz, 6);

    // Reset in the middle of a tile, then a clean tile
    run_a(v, -1, 12);
    v.delete();
    for (int i = 0; i < 25; i++) v.push_back(0);
    v[5] = 32'h7; v[20] = 32'hBEEF;
    run_a(v, -1, -1);
    check("t6_entry_count", a_got_d.size(), 2);
    if (a_got_d.size() == 2) begin
      check("t6_e0_data", a_got_d[0], 32'h7);    check("t6_e0_ind", a_got_i[0], 5);
      check("t6_e1_data", a_got_d[1], 32'hBEEF); check("t6_e1_ind", a_got_i[1], 14);
    end
    check("t6_nz", a_nz, 2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
